// File: rtl/ir_prefetch_queue.sv
// Instruction register fed by a DEPTH-entry prefetch FIFO from Dbus, with explicit
// advance (Next), jump flush, occupancy/overflow status and a tri-state address drive.
module ir_prefetch_queue #(
   parameter int WORD_WIDTH    = 8,
   parameter int ADDRESS_WIDTH = 5,
   parameter int DEPTH         = 4,
   parameter int CNT_WIDTH     = $clog2(DEPTH + 1)
) (
   input  logic                              CLK,
   input  logic                              RSTn,
   input  logic                              Din,
   input  logic                              Next,
   input  logic                              Flush,
   input  logic                              Aout,
   input  logic [WORD_WIDTH-1:0]             Dbus,
   output logic [ADDRESS_WIDTH-1:0]          Abus,
   output logic [WORD_WIDTH-ADDRESS_WIDTH-1:0] instr,
   output logic [WORD_WIDTH-1:0]             I,
   output logic                              I_valid,
   output logic [CNT_WIDTH-1:0]              count,
   output logic                              full,
   output logic                              empty,
   output logic                              ovf
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // Din is a push request and Next a pop request; neither is back-pressured.
   // A push into a full queue is dropped (ovf) unless a pop frees a slot on the same edge.
   logic [WORD_WIDTH-1:0] mem_q [DEPTH];
   logic [WORD_WIDTH-1:0] mem_d [DEPTH];
   logic [WORD_WIDTH-1:0] i_q, i_d;
   logic                  i_valid_q, i_valid_d;
   logic [CNT_WIDTH-1:0]  count_q, count_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic                  ovf_q, ovf_d;

   logic is_full, is_empty;
   logic do_pop, do_bypass, do_push, do_drop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign is_full  = (count_q == CNT_WIDTH'(DEPTH));
   assign is_empty = (count_q == '0);

   always_comb begin
      mem_d     = mem_q;
      i_d       = i_q;
      i_valid_d = i_valid_q;
      count_d   = count_q;
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      ovf_d     = ovf_q;
      do_pop    = 1'b0;
      do_bypass = 1'b0;
      do_push   = 1'b0;
      do_drop   = 1'b0;

      if (Flush) begin
         count_d   = '0;
         rd_ptr_d  = '0;
         wr_ptr_d  = '0;
         i_valid_d = 1'b0;
         ovf_d     = 1'b0;
      end else begin
         do_pop    = Next && !is_empty;
         do_bypass = Next && is_empty && Din;
         do_push   = Din && !do_bypass && (!is_full || Next);
         do_drop   = Din && is_full && !Next;

         // When full with a pop, wr_ptr equals rd_ptr; the pop reads the old entry from mem_q.
         if (do_push) begin
            mem_d[wr_ptr_q] = Dbus;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
         end
         if (do_drop)
            ovf_d = 1'b1;

         if (do_pop) begin
            i_d       = mem_q[rd_ptr_q];
            i_valid_d = 1'b1;
            rd_ptr_d  = ptr_inc(rd_ptr_q);
         end else if (do_bypass) begin
            i_d       = Dbus;
            i_valid_d = 1'b1;
         end else if (Next) begin
            i_valid_d = 1'b0;
         end

         if (do_push && !do_pop)
            count_d = count_q + CNT_WIDTH'(1);
         else if (do_pop && !do_push)
            count_d = count_q - CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         for (int k = 0; k < DEPTH; k++)
            mem_q[k] <= '0;
         i_q       <= '0;
         i_valid_q <= 1'b0;
         count_q   <= '0;
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         ovf_q     <= 1'b0;
      end else begin
         for (int k = 0; k < DEPTH; k++)
            mem_q[k] <= mem_d[k];
         i_q       <= i_d;
         i_valid_q <= i_valid_d;
         count_q   <= count_d;
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         ovf_q     <= ovf_d;
      end
   end

   assign Abus    = Aout ? i_q[ADDRESS_WIDTH-1:0] : 'z;
   assign instr   = i_q[WORD_WIDTH-1:ADDRESS_WIDTH];
   assign I       = i_q;
   assign I_valid = i_valid_q;
   assign count   = count_q;
   assign full    = is_full;
   assign empty   = is_empty;
   assign ovf     = ovf_q;

endmodule

// File: tb/tb_ir_prefetch_queue.sv
// Directed vector bench for ir_prefetch_queue (WORD_WIDTH=8, ADDRESS_WIDTH=5, DEPTH=4).
module tb_ir_prefetch_queue;

   localparam int WW = 8;
   localparam int AW = 5;
   localparam int DP = 4;
   localparam int CW = $clog2(DP + 1);

   logic          CLK = 1'b0;
   logic          RSTn, Din, Next, Flush, Aout;
   logic [WW-1:0] Dbus;
   logic [AW-1:0] Abus;
   logic [WW-AW-1:0] instr;
   logic [WW-1:0] I;
   logic          I_valid;
   logic [CW-1:0] count;
   logic          full, empty, ovf;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic       rstn;
      logic       din;
      logic       nxt;
      logic       flush;
      logic       aout;
      logic [7:0] dbus;
      logic [7:0] e_i;
      logic       e_v;
      int         e_cnt;
      logic       e_ovf;
   } vec_t;

   vec_t vq[$];
   logic [WW-1:0] exp_q[$];

   ir_prefetch_queue #(.WORD_WIDTH(WW), .ADDRESS_WIDTH(AW), .DEPTH(DP)) dut (
      .CLK(CLK), .RSTn(RSTn), .Din(Din), .Next(Next), .Flush(Flush), .Aout(Aout),
      .Dbus(Dbus), .Abus(Abus), .instr(instr), .I(I), .I_valid(I_valid),
      .count(count), .full(full), .empty(empty), .ovf(ovf)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input int row, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
      end
   endtask

   task automatic add(input logic rstn, input logic din, input logic nxt, input logic flush,
                      input logic aout, input logic [7:0] dbus, input logic [7:0] e_i,
                      input logic e_v, input int e_cnt, input logic e_ovf);
      vq.push_back('{rstn, din, nxt, flush, aout, dbus, e_i, e_v, e_cnt, e_ovf});
   endtask

   task automatic drive(input logic rstn, input logic din, input logic nxt,
                        input logic flush, input logic aout, input logic [7:0] dbus);
      @(negedge CLK);
      RSTn = rstn; Din = din; Next = nxt; Flush = flush; Aout = aout; Dbus = dbus;
      @(posedge CLK);
      #1;
   endtask

   task automatic check_state(input int row, input logic [7:0] e_i, input logic e_v,
                              input int e_cnt, input logic e_ovf, input logic aout);
      logic [7:0] e_tmp;
      e_tmp = e_i;
      check("I", row, 32'(I), 32'(e_i));
      check("I_valid", row, 32'(I_valid), 32'(e_v));
      check("count", row, 32'(count), 32'(e_cnt));
      check("full", row, 32'(full), 32'(e_cnt == DP));
      check("empty", row, 32'(empty), 32'(e_cnt == 0));
      check("ovf", row, 32'(ovf), 32'(e_ovf));
      check("instr", row, 32'(instr), 32'(e_tmp[7:5]));
      if (aout)
         check("Abus", row, 32'(Abus), 32'(e_tmp[4:0]));
   endtask

   initial begin
      RSTn = 1'b0; Din = 1'b0; Next = 1'b0; Flush = 1'b0; Aout = 1'b0; Dbus = '0;

      //  rstn din nxt fl aout dbus   I     v  cnt ovf
      add(0, 1, 0, 0, 1, 8'hFF, 8'h00, 0, 0, 0);  // reset with a pending push
      add(1, 1, 0, 0, 0, 8'hA1, 8'h00, 0, 1, 0);
      add(1, 1, 0, 0, 0, 8'hB2, 8'h00, 0, 2, 0);
      add(1, 1, 0, 0, 0, 8'hC3, 8'h00, 0, 3, 0);
      add(1, 1, 0, 0, 0, 8'hD4, 8'h00, 0, 4, 0);
      add(1, 0, 1, 0, 0, 8'h00, 8'hA1, 1, 3, 0);
      add(1, 0, 1, 0, 1, 8'h00, 8'hB2, 1, 2, 0);  // Abus 5'h12, instr 3'b101
      add(1, 0, 0, 0, 1, 8'h00, 8'hB2, 1, 2, 0);  // idle holds I
      add(1, 1, 0, 0, 0, 8'hE5, 8'hB2, 1, 3, 0);
      add(1, 1, 0, 0, 0, 8'hF6, 8'hB2, 1, 4, 0);  // wr_ptr wrapped
      add(1, 0, 1, 0, 0, 8'h00, 8'hC3, 1, 3, 0);
      add(1, 0, 1, 0, 0, 8'h00, 8'hD4, 1, 2, 0);
      add(1, 0, 1, 0, 0, 8'h00, 8'hE5, 1, 1, 0);
      add(1, 0, 1, 0, 1, 8'h00, 8'hF6, 1, 0, 0);
      add(1, 1, 0, 0, 0, 8'h11, 8'hF6, 1, 1, 0);
      add(1, 1, 0, 0, 0, 8'h22, 8'hF6, 1, 2, 0);
      add(1, 1, 0, 0, 0, 8'h33, 8'hF6, 1, 3, 0);
      add(1, 1, 0, 0, 0, 8'h44, 8'hF6, 1, 4, 0);
      add(1, 1, 0, 0, 0, 8'h77, 8'hF6, 1, 4, 1);  // dropped
      add(1, 1, 1, 0, 0, 8'h88, 8'h11, 1, 4, 1);  // push+pop while full
      add(1, 0, 1, 0, 0, 8'h00, 8'h22, 1, 3, 1);
      add(1, 0, 1, 0, 0, 8'h00, 8'h33, 1, 2, 1);
      add(1, 0, 1, 0, 0, 8'h00, 8'h44, 1, 1, 1);
      add(1, 0, 1, 0, 0, 8'h00, 8'h88, 1, 0, 1);
      add(1, 0, 1, 0, 0, 8'h00, 8'h88, 0, 0, 1);  // underrun
      add(1, 1, 1, 0, 1, 8'h3C, 8'h3C, 1, 0, 1);  // bypass
      add(1, 0, 1, 0, 0, 8'h00, 8'h3C, 0, 0, 1);
      add(1, 1, 0, 0, 0, 8'h01, 8'h3C, 0, 1, 1);
      add(1, 1, 0, 0, 0, 8'h02, 8'h3C, 0, 2, 1);
      add(1, 1, 0, 0, 0, 8'h03, 8'h3C, 0, 3, 1);
      add(1, 1, 0, 0, 0, 8'h04, 8'h3C, 0, 4, 1);
      add(1, 0, 1, 0, 0, 8'h00, 8'h01, 1, 3, 1);
      add(1, 1, 1, 1, 0, 8'h99, 8'h01, 0, 0, 0);  // flush wins over push and pop
      add(1, 1, 0, 0, 0, 8'h5A, 8'h01, 0, 1, 0);
      add(1, 0, 1, 0, 1, 8'h00, 8'h5A, 1, 0, 0);
      add(1, 1, 0, 0, 0, 8'h10, 8'h5A, 1, 1, 0);
      add(1, 1, 0, 0, 0, 8'h20, 8'h5A, 1, 2, 0);
      add(1, 1, 0, 0, 0, 8'h30, 8'h5A, 1, 3, 0);
      add(1, 1, 0, 0, 0, 8'h40, 8'h5A, 1, 4, 0);
      add(1, 1, 0, 0, 0, 8'h50, 8'h5A, 1, 4, 1);
      add(1, 0, 1, 0, 0, 8'h00, 8'h10, 1, 3, 1);
      add(1, 0, 1, 0, 0, 8'h00, 8'h20, 1, 2, 1);
      add(0, 1, 0, 0, 1, 8'h66, 8'h00, 0, 0, 0);  // reset mid-operation
      add(1, 0, 1, 0, 0, 8'h00, 8'h00, 0, 0, 0);  // 8'h66 was not queued

      for (int r = 0; r < vq.size(); r++) begin
         drive(vq[r].rstn, vq[r].din, vq[r].nxt, vq[r].flush, vq[r].aout, vq[r].dbus);
         check_state(r, vq[r].e_i, vq[r].e_v, vq[r].e_cnt, vq[r].e_ovf, vq[r].aout);
      end

      // Streaming: one word in flight, then simultaneous push/pop each cycle keeps count at 1
      drive(1, 1, 0, 0, 0, 8'hC0);
      exp_q.push_back(8'hC0);
      check("stream_count", 100, 32'(count), 32'd1);
      for (int k = 1; k <= 6; k++) begin
         logic [7:0] w;
         logic [7:0] e;
         w = 8'hC0 + 8'(k);
         exp_q.push_back(w);
         e = exp_q.pop_front();
         drive(1, 1, 1, 0, 1, w);
         check_state(100 + k, e, 1'b1, 1, 1'b0, 1'b1);
      end

      // Latency: pushed words are poppable on the very next edge in order
      drive(1, 0, 1, 0, 0, 8'h00);
      check_state(110, exp_q.pop_front(), 1'b1, 0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
